// File: rtl/traffic_light_conflict_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_conflict_monitor
//  Purpose  : Safety stage between the traffic light controller and the lamp
//             drivers. Legal phases are passed through two cycles late, and any
//             violation latches a fault and flashes red until it is cleared.
//  Options  : TLM_AUTO_RECOVER_EN - leave FAULT after RECOVER_CYCLES of red.
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_light_conflict_monitor #(
    parameter int MIN_DWELL      = 3,
    parameter int MAX_DWELL      = 20,
    parameter int FLASH_HALF     = 4,
    parameter int RECOVER_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] lights_in,
    input  logic       fault_clr,
    output logic [2:0] lamp_out,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int c_DWELL_W = $clog2(MAX_DWELL + 1);
    localparam int c_FLASH_W = $clog2(2 * FLASH_HALF);

    localparam logic [c_DWELL_W-1:0] c_MIN_DWELL  = c_DWELL_W'(MIN_DWELL);
    localparam logic [c_DWELL_W-1:0] c_MAX_DWELL  = c_DWELL_W'(MAX_DWELL);
    localparam logic [c_FLASH_W-1:0] c_FLASH_HALF = c_FLASH_W'(FLASH_HALF);
    localparam logic [c_FLASH_W-1:0] c_FLASH_LAST = c_FLASH_W'(2 * FLASH_HALF - 1);

    localparam logic [2:0] c_RED  = 3'b100;
    localparam logic [2:0] c_YEL  = 3'b010;
    localparam logic [2:0] c_GRN  = 3'b001;
    localparam logic [2:0] c_DARK = 3'b000;

    localparam logic [2:0] c_CODE_NONE       = 3'd0;
    localparam logic [2:0] c_CODE_PATTERN    = 3'd1;
    localparam logic [2:0] c_CODE_TRANSITION = 3'd2;
    localparam logic [2:0] c_CODE_MIN_DWELL  = 3'd3;
    localparam logic [2:0] c_CODE_STUCK      = 3'd4;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    state_t               r_state;
    logic [2:0]           r_lights_q;
    logic [2:0]           r_last_q;
    logic [c_DWELL_W-1:0] r_dwell_cnt;
    logic [c_FLASH_W-1:0] r_flash_cnt;

    logic                 w_onehot;
    logic                 w_changed;
    logic                 w_legal_chg;
    logic [2:0]           w_code;
    logic [c_FLASH_W-1:0] w_flash_next;
    logic                 w_manual_clr;
    logic                 w_auto_clr;

    assign w_onehot    = (r_lights_q == c_RED) || (r_lights_q == c_YEL) || (r_lights_q == c_GRN);
    assign w_changed   = (r_lights_q != r_last_q);
    assign w_legal_chg = ((r_last_q == c_GRN) && (r_lights_q == c_YEL)) ||
                         ((r_last_q == c_YEL) && (r_lights_q == c_RED)) ||
                         ((r_last_q == c_RED) && (r_lights_q == c_GRN));

    // Priority order matters: the first matching cause is the one latched.
    always_comb begin
        w_code = c_CODE_NONE;
        if (!w_onehot)
            w_code = c_CODE_PATTERN;
        else if (w_changed && !w_legal_chg)
            w_code = c_CODE_TRANSITION;
        else if (w_changed && (r_dwell_cnt < c_MIN_DWELL))
            w_code = c_CODE_MIN_DWELL;
        else if (!w_changed && (r_dwell_cnt == c_MAX_DWELL))
            w_code = c_CODE_STUCK;
    end

    assign w_flash_next = (r_flash_cnt == c_FLASH_LAST) ? '0 : r_flash_cnt + c_FLASH_W'(1);
    assign w_manual_clr = fault_clr && (r_lights_q == c_RED);

`ifdef TLM_AUTO_RECOVER_EN
    localparam int c_REC_W = $clog2(RECOVER_CYCLES + 1);
    localparam logic [c_REC_W-1:0] c_REC_LAST = c_REC_W'(RECOVER_CYCLES - 1);

    logic [c_REC_W-1:0] r_rec_cnt;

    // Counts consecutive red inputs seen while faulted; any other pattern restarts it.
    assign w_auto_clr = (r_state == ST_FAULT) && (r_lights_q == c_RED) && (r_rec_cnt == c_REC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rec_cnt <= '0;
        else if ((r_state == ST_FAULT) && (r_lights_q == c_RED) && !w_auto_clr)
            r_rec_cnt <= r_rec_cnt + c_REC_W'(1);
        else
            r_rec_cnt <= '0;
    end
`else
    // Recovery compiled out; the parameter stays referenced so both builds share one interface.
    assign w_auto_clr = 1'b0 && (RECOVER_CYCLES > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_STARTUP;
            r_lights_q  <= c_RED;
            r_last_q    <= c_RED;
            r_dwell_cnt <= '0;
            r_flash_cnt <= '0;
            lamp_out    <= c_RED;
            fault       <= 1'b0;
            fault_code  <= c_CODE_NONE;
        end else begin
            r_lights_q <= lights_in;
            case (r_state)
                ST_STARTUP: begin
                    lamp_out <= c_RED;
                    if (r_lights_q == c_RED) begin
                        r_state     <= ST_MONITOR;
                        r_last_q    <= c_RED;
                        r_dwell_cnt <= c_DWELL_W'(1);
                    end
                end
                ST_MONITOR: begin
                    if (w_code != c_CODE_NONE) begin
                        r_state     <= ST_FAULT;
                        fault       <= 1'b1;
                        fault_code  <= w_code;
                        lamp_out    <= c_RED;
                        r_flash_cnt <= '0;
                    end else begin
                        lamp_out <= r_lights_q;
                        r_last_q <= r_lights_q;
                        if (w_changed)
                            r_dwell_cnt <= c_DWELL_W'(1);
                        else if (r_dwell_cnt != c_MAX_DWELL)
                            r_dwell_cnt <= r_dwell_cnt + c_DWELL_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (w_manual_clr || w_auto_clr) begin
                        r_state     <= ST_STARTUP;
                        fault       <= 1'b0;
                        fault_code  <= c_CODE_NONE;
                        lamp_out    <= c_RED;
                        r_last_q    <= c_RED;
                        r_dwell_cnt <= '0;
                        r_flash_cnt <= '0;
                    end else begin
                        r_flash_cnt <= w_flash_next;
                        lamp_out    <= (w_flash_next < c_FLASH_HALF) ? c_RED : c_DARK;
                    end
                end
                default: begin
                    r_state  <= ST_STARTUP;
                    lamp_out <= c_RED;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_conflict_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_conflict_monitor
//  Purpose  : Scenario bench for the lamp conflict monitor, reference-model scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_conflict_monitor;

    localparam int MIN_DWELL      = 3;
    localparam int MAX_DWELL      = 20;
    localparam int FLASH_HALF     = 4;
    localparam int RECOVER_CYCLES = 16;

    typedef struct packed {
        logic [2:0] lamp;
        logic       flt;
        logic [2:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] lights_in;
    logic       fault_clr;
    logic [2:0] lamp_out;
    logic       fault;
    logic [2:0] fault_code;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t       exp_q[$];
    logic [3:0] stim_q[$];

    // Reference model state: phase held count is unbounded, flash tracked by fault age.
    int         m_state;
    logic [2:0] m_lq;
    logic [2:0] m_last;
    int         m_run;
    int         m_age;
    int         m_rec;
    logic [2:0] m_lamp;
    logic       m_fault;
    logic [2:0] m_code;

    traffic_light_conflict_monitor #(
        .MIN_DWELL      (MIN_DWELL),
        .MAX_DWELL      (MAX_DWELL),
        .FLASH_HALF     (FLASH_HALF),
        .RECOVER_CYCLES (RECOVER_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lights_in  (lights_in),
        .fault_clr  (fault_clr),
        .lamp_out   (lamp_out),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_state = 0; m_lq = 3'b100; m_last = 3'b100; m_run = 0; m_age = 0; m_rec = 0;
        m_lamp = 3'b100; m_fault = 1'b0; m_code = 3'd0;
    endtask

    task automatic model_step(input logic [2:0] lq, input logic clr, output exp_t e);
        logic onehot, legal, do_clr;
        int   cause;
        case (m_state)
            0: begin
                m_lamp = 3'b100;
                if (lq == 3'b100) begin m_state = 1; m_last = 3'b100; m_run = 1; end
            end
            1: begin
                onehot = (lq == 3'b100) || (lq == 3'b010) || (lq == 3'b001);
                legal  = (m_last == 3'b001 && lq == 3'b010) || (m_last == 3'b010 && lq == 3'b100) ||
                         (m_last == 3'b100 && lq == 3'b001);
                cause = 0;
                if (!onehot) cause = 1;
                else if (lq != m_last && !legal) cause = 2;
                else if (lq != m_last && m_run < MIN_DWELL) cause = 3;
                else if (lq == m_last && m_run >= MAX_DWELL) cause = 4;
                if (cause != 0) begin
                    m_state = 2; m_fault = 1'b1; m_code = 3'(cause); m_age = 0; m_rec = 0; m_lamp = 3'b100;
                end else begin
                    m_lamp = lq;
                    m_run  = (lq != m_last) ? 1 : m_run + 1;
                    m_last = lq;
                end
            end
            default: begin
                do_clr = clr && (lq == 3'b100);
`ifdef TLM_AUTO_RECOVER_EN
                m_rec = (lq == 3'b100) ? m_rec + 1 : 0;
                if (m_rec == RECOVER_CYCLES) do_clr = 1'b1;
`endif
                if (do_clr) begin
                    m_state = 0; m_fault = 1'b0; m_code = 3'd0; m_lamp = 3'b100; m_rec = 0;
                end else begin
                    m_age  = m_age + 1;
                    m_lamp = ((m_age % (2 * FLASH_HALF)) < FLASH_HALF) ? 3'b100 : 3'b000;
                end
            end
        endcase
        e = '{lamp: m_lamp, flt: m_fault, code: m_code};
    endtask

    task automatic add(input logic [2:0] pat, input int n, input logic clr);
        for (int i = 0; i < n; i++) stim_q.push_back({clr, pat});
    endtask

    // Drives one cycle: the model sees the previous input as the registered pattern.
    task automatic drive(input logic [3:0] s);
        exp_t e;
        model_step(m_lq, s[3], e);
        m_lq = s[2:0];
        exp_q.push_back(e);
        lights_in = s[2:0];
        fault_clr = s[3];
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; lights_in = 3'b100; fault_clr = 1'b0;
        #2;
        n_checks++;
        if (lamp_out !== 3'b100) begin n_fail++; $display("FAIL reset_lamp: got %b exp 100", lamp_out); end
        n_checks++;
        if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b exp 0", fault); end
        n_checks++;
        if (fault_code !== 3'd0) begin n_fail++; $display("FAIL reset_code: got %0d exp 0", fault_code); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_legal_sequence();
        exp_t e;
        add(3'b100, 5, 1'b0); add(3'b001, 5, 1'b0); add(3'b010, 5, 1'b0); add(3'b100, 5, 1'b0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if ({lamp_out, fault, fault_code} !== e) begin
                n_fail++;
                $display("FAIL legal_seq: lamp/fault/code got %b/%b/%0d exp %b/%b/%0d",
                         lamp_out, fault, fault_code, e.lamp, e.flt, e.code);
            end
        end
    endtask

    task automatic test_illegal_pattern();
        exp_t e;
        add(3'b110, 1, 1'b0); add(3'b100, 18, 1'b0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if ({lamp_out, fault, fault_code} !== e) begin
                n_fail++;
                $display("FAIL illegal_pattern: lamp/fault/code got %b/%b/%0d exp %b/%b/%0d",
                         lamp_out, fault, fault_code, e.lamp, e.flt, e.code);
            end
        end
        n_checks++;
        if (fault_code !== 3'd1) begin n_fail++; $display("FAIL pattern_code: got %0d exp 1", fault_code); end
    endtask

    task automatic test_illegal_transition();
        exp_t e;
        add(3'b100, 1, 1'b1);
        add(3'b100, 4, 1'b0); add(3'b001, 5, 1'b0); add(3'b100, 3, 1'b0);
        add(3'b001, 1, 1'b0); add(3'b001, 1, 1'b1); add(3'b001, 1, 1'b0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if ({lamp_out, fault, fault_code} !== e) begin
                n_fail++;
                $display("FAIL illegal_transition: lamp/fault/code got %b/%b/%0d exp %b/%b/%0d",
                         lamp_out, fault, fault_code, e.lamp, e.flt, e.code);
            end
        end
        n_checks++;
        if ({fault, fault_code} !== {1'b1, 3'd2}) begin
            n_fail++; $display("FAIL transition_code: fault/code got %b/%0d exp 1/2", fault, fault_code);
        end
    endtask

    task automatic test_min_dwell();
        exp_t e;
        add(3'b100, 1, 1'b0); add(3'b100, 1, 1'b1);
        add(3'b100, 4, 1'b0); add(3'b001, 4, 1'b0); add(3'b010, 4, 1'b0);
        add(3'b100, 2, 1'b0); add(3'b001, 3, 1'b0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if ({lamp_out, fault, fault_code} !== e) begin
                n_fail++;
                $display("FAIL min_dwell: lamp/fault/code got %b/%b/%0d exp %b/%b/%0d",
                         lamp_out, fault, fault_code, e.lamp, e.flt, e.code);
            end
        end
        n_checks++;
        if (fault_code !== 3'd3) begin n_fail++; $display("FAIL min_dwell_code: got %0d exp 3", fault_code); end
    endtask

    task automatic test_stuck();
        exp_t e;
        add(3'b100, 1, 1'b0); add(3'b100, 1, 1'b1); add(3'b100, 25, 1'b0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if ({lamp_out, fault, fault_code} !== e) begin
                n_fail++;
                $display("FAIL stuck: lamp/fault/code got %b/%b/%0d exp %b/%b/%0d",
                         lamp_out, fault, fault_code, e.lamp, e.flt, e.code);
            end
        end
        n_checks++;
        if (fault_code !== 3'd4) begin n_fail++; $display("FAIL stuck_code: got %0d exp 4", fault_code); end
    endtask

    task automatic test_back_to_back_clr();
        exp_t e;
        add(3'b100, 1, 1'b1);
        add(3'b100, 4, 1'b0); add(3'b001, 4, 1'b0);
        add(3'b100, 1, 1'b0); add(3'b100, 1, 1'b1); add(3'b100, 6, 1'b0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if ({lamp_out, fault, fault_code} !== e) begin
                n_fail++;
                $display("FAIL clr_collision: lamp/fault/code got %b/%b/%0d exp %b/%b/%0d",
                         lamp_out, fault, fault_code, e.lamp, e.flt, e.code);
            end
        end
        n_checks++;
        if ({fault, fault_code} !== {1'b1, 3'd2}) begin
            n_fail++; $display("FAIL collision_code: fault/code got %b/%0d exp 1/2", fault, fault_code);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        add(3'b100, 5, 1'b0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if ({lamp_out, fault, fault_code} !== e) begin
                n_fail++;
                $display("FAIL pre_reset_flash: lamp/fault/code got %b/%b/%0d exp %b/%b/%0d",
                         lamp_out, fault, fault_code, e.lamp, e.flt, e.code);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({lamp_out, fault, fault_code} !== {3'b100, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL async_reset: lamp/fault/code got %b/%b/%0d exp 100/0/0", lamp_out, fault, fault_code);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    task automatic test_recovery();
        exp_t e;
        add(3'b100, 4, 1'b0); add(3'b110, 1, 1'b0); add(3'b100, 9, 1'b0);
        add(3'b001, 1, 1'b0); add(3'b100, 20, 1'b0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_checks++;
            if ({lamp_out, fault, fault_code} !== e) begin
                n_fail++;
                $display("FAIL recovery: lamp/fault/code got %b/%b/%0d exp %b/%b/%0d",
                         lamp_out, fault, fault_code, e.lamp, e.flt, e.code);
            end
        end
`ifdef TLM_AUTO_RECOVER_EN
        n_checks++;
        if (fault !== 1'b0) begin n_fail++; $display("FAIL auto_clear: fault got %b exp 0", fault); end
`else
        n_checks++;
        if (fault !== 1'b1) begin n_fail++; $display("FAIL no_auto_clear: fault got %b exp 1", fault); end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_legal_sequence();
        test_illegal_pattern();
        test_illegal_transition();
        test_min_dwell();
        test_stuck();
        test_back_to_back_clr();
        test_async_reset();
        test_recovery();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
